// File: rtl/ring_freq_meter.sv
// ----------------------------------------------------------------------------
// ring_freq_meter
//
// Measures the speed of a free-running ring oscillator against the board
// clock. On request it enables the oscillator, lets it run for SETTLE_CYCLES,
// then counts rising edges of the prescaled oscillator tap for GATE_CYCLES
// clock cycles and publishes the (saturating) edge count.
//
// Parameters:
//   GATE_CYCLES   gate window length in clk cycles (>= 1)
//   SETTLE_CYCLES oscillator warm-up before gating, edges ignored (>= 1)
//   CNT_W         width of the edge accumulator / result
//
// Ports:
//   clk       board clock, the only clock of the block
//   rst_n     asynchronous active-low reset
//   start     measurement request, only honoured while idle
//   osc_in    prescaled oscillator tap, asynchronous to clk
//   osc_en    oscillator enable
//   busy      a measurement is in progress (settle, gate or done cycle)
//   valid     one-cycle pulse when count/overflow are updated
//   count     result of the last completed measurement
//   overflow  last measurement saturated
//
// Build option:
//   RING_FREQ_METER_CONTINUOUS_EN  when defined, the done cycle loops straight
//   back into a new gate window (first window needs one start), with no gap
//   in edge counting between windows.
// ----------------------------------------------------------------------------
module ring_freq_meter #(
  parameter int GATE_CYCLES   = 1200000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int GATE_W   = $clog2(GATE_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    ACC_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                prev_q, prev_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                edge_seen;

  // Two-flop synchronizer, then a one-flop history for edge detection.
  // A pin rising edge is seen three clk cycles after the transition.
  always_comb begin
    sync1_d   = osc_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    edge_seen = sync2_q & ~prev_q;
  end

  // NOTE: every signal gets a default before the case so that no path leaves
  // one unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    osc_en       = 1'b0;
    busy         = 1'b0;
    valid        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
          acc_d        = '0;
          ovf_d        = 1'b0;
        end
      end

      S_SETTLE: begin
        osc_en = 1'b1;
        busy   = 1'b1;
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d    = S_GATE;
          gate_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      S_GATE: begin
        osc_en = 1'b1;
        busy   = 1'b1;
        // Saturate rather than wrap; an increment lost at the ceiling is
        // remembered in the sticky overflow bit.
        if (edge_seen) begin
          if (acc_q == ACC_MAX) begin
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_q + 1'b1;
          end
        end
        // The result is latched on the way out of the last gate cycle, so it
        // is already visible on count while valid is high in the done cycle.
        if (gate_cnt_q == GATE_LAST) begin
          state_d    = S_DONE;
          count_d    = acc_d;
          overflow_d = ovf_d;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        busy  = 1'b1;
        valid = 1'b1;
`ifdef RING_FREQ_METER_CONTINUOUS_EN
        // The done cycle is the first cycle of the next window: an edge seen
        // here becomes its first count.
        osc_en     = 1'b1;
        state_d    = S_GATE;
        gate_cnt_d = '0;
        acc_d      = CNT_W'(edge_seen);
        ovf_d      = 1'b0;
`else
        state_d = S_IDLE;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      settle_cnt_q <= '0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      settle_cnt_q <= settle_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// ----------------------------------------------------------------------------
// tb_ring_freq_meter
//
// Self-checking bench for ring_freq_meter (GATE_CYCLES=100, SETTLE_CYCLES=8,
// CNT_W=4). The reference model works purely in clock-edge numbers: it
// records the oscillator level sampled at every edge, and for a measurement
// started at edge t it counts rising transitions whose detection cycle falls
// inside the gate window, then saturates. A compare process checks every
// output against the model on every falling clock edge; directed scenarios
// add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ring_freq_meter;

  localparam int S     = 8;
  localparam int G     = 100;
  localparam int W     = 4;
  localparam int MAXV  = (1 << W) - 1;
  localparam int HIST  = 65536;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic         osc_in   = 1'b0;
  logic         osc_en;
  logic         busy;
  logic         valid;
  logic [W-1:0] count;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  ring_freq_meter #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .osc_in  (osc_in),
    .osc_en  (osc_en),
    .busy    (busy),
    .valid   (valid),
    .count   (count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- oscillator stimulus ----------------
  // mode 0: level from osc_manual; mode 1: fixed high/low phase lengths;
  // mode 2: random phase lengths of 2..7 cycles.
  int   osc_mode   = 0;
  int   hi_len     = 5;
  int   lo_len     = 5;
  logic osc_manual = 1'b0;

  initial begin
    int ph_left;
    ph_left = 1;
    forever begin
      @(negedge clk);
      if (osc_mode == 0) begin
        osc_in = osc_manual;
      end else if (ph_left > 1) begin
        ph_left--;
      end else begin
        osc_in = ~osc_in;
        if (osc_mode == 1) ph_left = osc_in ? hi_len : lo_len;
        else               ph_left = $urandom_range(2, 7);
      end
    end
  end

  // ---------------- reference model ----------------
  int   edge_no = 0;
  bit   pin_hist [HIST];
  int   m_t     = -1;   // edge at which the current measurement was accepted
  int   m_lo    = 0;    // first sample edge whose rise is counted
  int   m_end   = 0;    // edge after which valid is shown
  int   m_count = 0;
  bit   m_ovf   = 1'b0;
  bit   m_busy  = 1'b0;
  bit   m_osc   = 1'b0;
  bit   m_valid = 1'b0;
  int   valid_seen = 0;

  // A rise sampled at edge n is detected in the cycle that ends at edge n+2.
  function automatic int count_rises(int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      if (i > 0 && i < HIST && pin_hist[i] && !pin_hist[i-1]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit fire;
    int n;
    fire = 1'b0;
    edge_no++;
    if (edge_no < HIST) pin_hist[edge_no] = rst_n && osc_in;
    if (!rst_n) begin
      m_t     = -1;
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        m_t   = edge_no;
        m_lo  = edge_no + S - 1;
        m_end = edge_no + S + G;
      end
    end else if (edge_no == m_end) begin
      fire    = 1'b1;
      n       = count_rises(m_lo, m_end - 2);
      m_count = (n > MAXV) ? MAXV : n;
      m_ovf   = (n > MAXV);
`ifdef RING_FREQ_METER_CONTINUOUS_EN
      m_lo  = m_end - 1;
      m_end = m_end + G + 1;
`endif
    end else if (edge_no == m_end + 1) begin
      m_t = -1;
    end
    m_valid = fire;
    m_busy  = (m_t >= 0);
`ifdef RING_FREQ_METER_CONTINUOUS_EN
    m_osc   = (m_t >= 0);
`else
    m_osc   = (m_t >= 0) && (edge_no < m_end);
`endif
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("busy_rst",  busy,     0);
      check("osc_en_rst", osc_en,  0);
      check("valid_rst", valid,    0);
      check("count_rst", count,    0);
      check("ovf_rst",   overflow, 0);
    end else begin
      check("busy",     busy,     m_busy);
      check("osc_en",   osc_en,   m_osc);
      check("valid",    valid,    m_valid);
      check("count",    count,    m_count);
      check("overflow", overflow, m_ovf);
    end
    if (valid === 1'b1) valid_seen++;
  end

  // ---------------- stimulus helpers ----------------
  // All helpers leave the caller 1 time unit after a rising clock edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(output int t);
    start = 1'b1;
    step(1);
    start = 1'b0;
    t = edge_no;
  endtask

  task automatic wait_valid(input int budget, output int v, output bit ok);
    ok = 1'b0;
    v  = -1;
    for (int i = 0; i < budget; i++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        v  = edge_no;
        return;
      end
      step(1);
    end
    check("valid_timeout", 0, 1);
  endtask

  task automatic run_meas(output int lat);
    int t, v;
    bit ok;
    do_start(t);
    wait_valid(250, v, ok);
    lat = ok ? (v - t + 1) : -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_osc"},   osc_en,   0);
    check({tag, "_valid"}, valid,    0);
    check({tag, "_count"}, count,    0);
    check({tag, "_ovf"},   overflow, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);
  endtask

  // Single rises sampled at t+off and t+off+G, each held high for 3 cycles.
  task automatic run_window(input int off, input string tag);
    int t, base, rel;
    base = valid_seen;
    do_start(t);
    for (int m = t; m <= t + S + G + 6; m++) begin
      rel = m + 1 - t;
      osc_manual = ((rel >= off && rel < off + 3) || (rel >= off + G && rel < off + G + 3));
      step(1);
    end
    check({tag, "_count"}, count, 1);
    check({tag, "_valids"}, valid_seen - base, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, t, v, base;
    bit ok;

    step(3);
    check_all_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1);

`ifdef RING_FREQ_METER_CONTINUOUS_EN
    osc_mode = 1; hi_len = 5; lo_len = 5;
    step(5);
    do_start(t);
    wait_valid(250, v, ok);
    check("cont_first_latency", v - t + 1, S + G + 1);
    for (int k = 0; k < 5; k++) begin
      int v1;
      step(1);
      wait_valid(250, v1, ok);
      check("cont_period", v1 - v, G + 1);
      check("cont_osc_en", osc_en, 1);
      v = v1;
    end
`else
    // Single-shot, period 10: 10 edges, latency S+G+1.
    osc_mode = 1; hi_len = 5; lo_len = 5;
    step(5);
    run_meas(lat);
    check("single_latency", lat, 109);
    check("single_count",   count, 10);
    check("single_ovf",     overflow, 0);
    check("single_busy",    busy, 1);
    step(3);

    // Saturation: period 4 gives 25 edges, clipped to 15.
    hi_len = 2; lo_len = 2;
    step(5);
    run_meas(lat);
    check("sat_count", count, 15);
    check("sat_ovf",   overflow, 1);
    step(3);
    osc_mode = 0; osc_manual = 1'b0;
    step(5);
    run_meas(lat);
    check("low_count", count, 0);
    check("low_ovf",   overflow, 0);
    step(3);

    // Busy rejection: extra starts mid-run and in the done cycle.
    osc_mode = 1; hi_len = 5; lo_len = 5;
    step(5);
    base = valid_seen;
    do_start(t);
    step(19);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid(250, v, ok);
    start = 1'b1; step(1); start = 1'b0;
    check("rej_busy_fall", busy, 0);
    step(150);
    check("rej_valids", valid_seen - base, 1);

    // Reset in the middle of the gate window.
    do_start(t);
    step(S + 50);
    pulse_reset();
    base = valid_seen;
    step(150);
    check("rst_no_valid", valid_seen - base, 0);
    run_meas(lat);
    check("rst_after_count", count, 10);
    step(3);

    // Window boundaries: last settle + last gate, then first gate + done.
    osc_mode = 0; osc_manual = 1'b0;
    step(5);
    run_window(S - 2, "win_a");
    run_window(S - 1, "win_b");

    // Randomised runs, including ignored starts while busy.
    for (int it = 0; it < 10; it++) begin
      osc_mode = $urandom_range(1, 2);
      hi_len   = $urandom_range(2, 9);
      lo_len   = $urandom_range(2, 9);
      step($urandom_range(1, 15));
      do_start(t);
      if ($urandom_range(0, 1) == 1) begin
        step($urandom_range(1, 100));
        start = 1'b1; step(1); start = 1'b0;
      end
      wait_valid(250, v, ok);
      step($urandom_range(1, 4));
    end
`endif

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Measures the frequency of a free-running ring oscillator against the board clock. It counts rising edges of a prescaled oscillator tap over a fixed gate window of `clk` cycles and reports the edge count. It sits beside the ring oscillator and drives its enable, so firmware or a debug path can read oscillator speed without any logic in the oscillator domain.

## Interface
- `GATE_CYCLES`, default 1200000: gate window length in `clk` cycles (100 ms at 12 MHz); must be ≥1.
- `SETTLE_CYCLES`, default 16: cycles the oscillator runs before gating starts. Edges in this window are ignored. Must be ≥1.
- `CNT_W`, default 24: width of the result counter.
- `clk`  in  1  board clock; the only clock of the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a measurement; sampled only in IDLE.
- `osc_in`  in  1  prescaled oscillator tap, asynchronous to `clk`. Each high and low phase must last ≥2 `clk` periods.
- `osc_en`  out  1  oscillator enable.
- `busy`  out  1  high in SETTLE, GATE and DONE.
- `valid`  out  1  one-cycle pulse when `count` is updated.
- `count`  out  CNT_W  result of the last completed measurement; holds between measurements.
- `overflow`  out  1  last measurement saturated; updated together with `count`.

## Operation
- **Input path:** two-flop synchronizer on `osc_in`, then a rising-edge detector (sync output high, previous sample low). An edge is therefore seen 3 `clk` cycles after the pin transition.
- **IDLE:**
  - `osc_en`=0, `busy`=0.
  - `start`=1 → SETTLE; the settle counter and edge accumulator are cleared.
- **SETTLE:**
  - `osc_en`=1, `busy`=1. Detected edges are discarded.
  - After exactly `SETTLE_CYCLES` cycles → GATE.
- **GATE:**
  - `osc_en`=1. Runs exactly `GATE_CYCLES` cycles.
  - Each cycle with a detected edge increments the accumulator.
  - The accumulator saturates at 2^CNT_W−1. An increment attempted at saturation sets a sticky internal overflow bit.
  - After the last gate cycle → DONE.
- **DONE (1 cycle):**
  - `count` ← accumulator, `overflow` ← sticky bit, `valid`=1, `osc_en`=0.
  - Then → IDLE.
- `start` in any state other than IDLE is ignored and is not queued.
- Gate counter width is clog2(GATE_CYCLES+1). The edge accumulator is CNT_W bits and never wraps.

## Timing
- **Reset values:** `osc_en`=0, `busy`=0, `valid`=0, `count`=0, `overflow`=0; state IDLE; synchronizer flops and accumulator cleared.
- **`start` sampled high at edge t (in IDLE):**
  - `busy`=`osc_en`=1 from t+1.
  - GATE occupies cycles t+1+SETTLE_CYCLES through t+SETTLE_CYCLES+GATE_CYCLES.
  - `valid`=1 in cycle t+1+SETTLE_CYCLES+GATE_CYCLES.
  - `busy`=0 from the following cycle.
  - Total latency from `start` to `valid` is SETTLE_CYCLES+GATE_CYCLES+1 cycles.
- **Window boundaries:** an edge detected in the first or last GATE cycle is counted. An edge detected in the DONE cycle or in the last SETTLE cycle is not.
- **`start` high in the DONE cycle:** ignored. `start` must be seen again in IDLE.
- **`rst_n` low mid-measurement:** all outputs return to reset values immediately. No `valid` is produced, and the previous `count` is lost.

## Configuration
- `RING_FREQ_METER_CONTINUOUS_EN`:
  - **Defined:** DONE goes directly to GATE with the accumulator cleared; `start` is needed only for the first measurement. `osc_en` and `busy` stay 1 through DONE, and `valid` pulses every GATE_CYCLES+1 cycles. There are no gaps: an edge seen in the DONE cycle is the first count of the next window.
  - **Undefined:** single-shot behaviour as described in Operation.

## Test plan
- **Single-shot count:** GATE_CYCLES=100, SETTLE_CYCLES=8, CNT_W=8, `osc_in` period 10 clk (5 high/5 low) running continuously → `valid` exactly 109 cycles after `start`, `count`=10, `overflow`=0.
- **Saturation:** CNT_W=4, `osc_in` period 4 clk, GATE_CYCLES=100 → 25 edges seen, `count`=15, `overflow`=1. A following run with `osc_in` held low → `count`=0, `overflow`=0.
- **Busy rejection:** `start` pulsed again 20 cycles after the first `start` and in the DONE cycle → exactly one `valid`. `busy` falls one cycle after `valid`.
- **Reset mid-GATE:** `rst_n` low at cycle 50 of GATE → all outputs 0 asynchronously. No `valid` is produced until a new `start`, after which `count`=10.
- **Window edges:** single `osc_in` rising transitions placed so detection lands in the last SETTLE cycle, the first GATE cycle, the last GATE cycle and the DONE cycle → `count`=2.
- **With `RING_FREQ_METER_CONTINUOUS_EN`:** one `start`, period-10 input → `valid` every 101 cycles, `count`=10 each time. `osc_en` stays 1 throughout.
